// File: rtl/decision_sched.sv
// Round-robin scheduler that time-shares one combinational decision tree
// between N_CH requesters, returning tagged one-hot decisions and per-class hit counts.
module decision_sched #(
   parameter int N_CH   = 4,
   parameter int FEAT_W = 10,
   parameter int CLS_W  = 3,
   parameter int CNT_W  = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_CH-1:0]          req_valid,
   output logic [N_CH-1:0]          req_ready,
   input  logic [N_CH*FEAT_W-1:0]   req_feat_1,
   input  logic [N_CH*FEAT_W-1:0]   req_feat_2,
   input  logic [N_CH*FEAT_W-1:0]   req_feat_3,
   output logic [FEAT_W-1:0]        tree_feat_1,
   output logic [FEAT_W-1:0]        tree_feat_2,
   output logic [FEAT_W-1:0]        tree_feat_3,
   input  logic [CLS_W-1:0]         tree_decision,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [$clog2(N_CH)-1:0]  res_ch,
   output logic [CLS_W-1:0]         res_decision,
   input  logic                     cnt_clr,
   output logic [CLS_W*CNT_W-1:0]   cls_cnt,
   output logic                     err_onehot,
   output logic [1:0]               fsm_state
);

   localparam int CH_W = $clog2(N_CH);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and a raised result valid holds its data until taken.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   rr_ptr, ch_q, grant_idx, idx;
   logic [N_CH-1:0]   grant;
   logic              any_valid, accept, capture, dec_onehot;
   logic [FEAT_W-1:0] feat_1_q, feat_2_q, feat_3_q;
   logic [CLS_W-1:0]  dec_q;
   logic [CNT_W-1:0]  cnt_q [CLS_W];

   // Search starts at rr_ptr and wraps naturally because N_CH is a power of two.
   always_comb begin
      any_valid = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int i = 0; i < N_CH; i++) begin
         idx = rr_ptr + CH_W'(i);
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            grant_idx = idx;
         end
      end
      grant = '0;
      grant[grant_idx] = any_valid;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               accept  = 1'b1;
               state_d = EVAL;
            end
         end
         EVAL: begin
            capture = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         feat_1_q <= '0;
         feat_2_q <= '0;
         feat_3_q <= '0;
         ch_q     <= '0;
         rr_ptr   <= '0;
         dec_q    <= '0;
      end else begin
         if (accept) begin
            feat_1_q <= req_feat_1[grant_idx*FEAT_W +: FEAT_W];
            feat_2_q <= req_feat_2[grant_idx*FEAT_W +: FEAT_W];
            feat_3_q <= req_feat_3[grant_idx*FEAT_W +: FEAT_W];
            ch_q     <= grant_idx;
            rr_ptr   <= grant_idx + CH_W'(1);
         end
         if (capture) dec_q <= tree_decision;
      end
   end

   assign dec_onehot = (tree_decision != '0) &&
                       ((tree_decision & (tree_decision - CLS_W'(1))) == '0);

   // A clear on the same edge as a capture wins over the increment and the error flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < CLS_W; i++) cnt_q[i] <= '0;
         err_onehot <= 1'b0;
      end else if (cnt_clr) begin
         for (int i = 0; i < CLS_W; i++) cnt_q[i] <= '0;
         err_onehot <= 1'b0;
      end else if (capture) begin
         if (dec_onehot) begin
            for (int i = 0; i < CLS_W; i++) begin
               if (tree_decision[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end else begin
            err_onehot <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < CLS_W; i++) begin : g_cnt
      assign cls_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assign req_ready    = (state_q == IDLE && RST) ? grant : '0;
   assign res_valid    = (state_q == OUT);
   assign res_ch       = ch_q;
   assign res_decision = dec_q;
   assign tree_feat_1  = feat_1_q;
   assign tree_feat_2  = feat_2_q;
   assign tree_feat_3  = feat_3_q;
   assign fsm_state    = state_q;

endmodule

// File: tb/tb_decision_sched.sv
// Bench for decision_sched: a model of the three-feature tree feeds the DUT,
// and expected {channel, decision} results are queued at stimulus time.
module tb_decision_sched;

   localparam int N_CH   = 4;
   localparam int FEAT_W = 10;
   localparam int CLS_W  = 3;
   localparam int CNT_W  = 4;
   localparam int W      = 2 + CLS_W;

   logic                     CLK, RST;
   logic [N_CH-1:0]          req_valid, req_ready;
   logic [N_CH*FEAT_W-1:0]   req_feat_1, req_feat_2, req_feat_3;
   logic [FEAT_W-1:0]        tree_feat_1, tree_feat_2, tree_feat_3;
   logic [CLS_W-1:0]         tree_decision, res_decision, stub_dec;
   logic                     res_valid, res_ready, cnt_clr, err_onehot, stub_en;
   logic [1:0]               res_ch, fsm_state;
   logic [CLS_W*CNT_W-1:0]   cls_cnt;
   logic [FEAT_W-1:0]        f1 [N_CH];
   logic [FEAT_W-1:0]        f2 [N_CH];
   logic [FEAT_W-1:0]        f3 [N_CH];
   logic [W-1:0]             exp_q [$];
   int                       n_checks = 0;
   int                       n_fail   = 0;
   int                       cyc      = 0;

   decision_sched #(.N_CH(N_CH), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .req_feat_1(req_feat_1), .req_feat_2(req_feat_2), .req_feat_3(req_feat_3),
      .tree_feat_1(tree_feat_1), .tree_feat_2(tree_feat_2), .tree_feat_3(tree_feat_3),
      .tree_decision(tree_decision), .res_valid(res_valid), .res_ready(res_ready),
      .res_ch(res_ch), .res_decision(res_decision), .cnt_clr(cnt_clr),
      .cls_cnt(cls_cnt), .err_onehot(err_onehot), .fsm_state(fsm_state)
   );

   function automatic logic [CLS_W-1:0] tree_fn(input logic [FEAT_W-1:0] a,
                                                input logic [FEAT_W-1:0] b,
                                                input logic [FEAT_W-1:0] c);
      if (a <= 367) begin
         if (a <= 287) return (b <= 655) ? 3'b001 : 3'b100;
         else          return (c <= 639) ? 3'b100 : 3'b010;
      end
      return 3'b010;
   endfunction

   for (genvar k = 0; k < N_CH; k++) begin : g_feat
      assign req_feat_1[k*FEAT_W +: FEAT_W] = f1[k];
      assign req_feat_2[k*FEAT_W +: FEAT_W] = f2[k];
      assign req_feat_3[k*FEAT_W +: FEAT_W] = f3[k];
   end

   assign tree_decision = stub_en ? stub_dec : tree_fn(tree_feat_1, tree_feat_2, tree_feat_3);

   // clock/reset block
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_res(output int k);
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLK);
         if (res_valid === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic pop_exp(output logic [W-1:0] e);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 'x;
   endtask

   task automatic push_exp(input logic [1:0] ch);
      exp_q.push_back({ch, tree_fn(f1[ch], f2[ch], f3[ch])});
   endtask

   task automatic test_reset();
      RST = 1'b0; req_valid = 4'hF; res_ready = 1'b0; cnt_clr = 1'b0;
      stub_en = 1'b0; stub_dec = '0;
      for (int i = 0; i < N_CH; i++) begin
         f1[i] = 10'(100 + i); f2[i] = 10'(200 + i); f3[i] = 10'(300 + i);
      end
      @(negedge CLK);
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      n_checks++; if (res_ch !== 2'd0 || res_decision !== 3'd0) begin n_fail++; $display("FAIL reset_res_data: got ch %0d dec %b want 0/000", res_ch, res_decision); end
      n_checks++; if ({tree_feat_1, tree_feat_2, tree_feat_3} !== '0) begin n_fail++; $display("FAIL reset_tree_feat: got %0d %0d %0d want 0", tree_feat_1, tree_feat_2, tree_feat_3); end
      n_checks++; if (cls_cnt !== '0 || err_onehot !== 1'b0) begin n_fail++; $display("FAIL reset_counters: got cnt %h err %b want 0/0", cls_cnt, err_onehot); end
      n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
      tick();
      RST = 1'b1; req_valid = '0;
   endtask

   task automatic test_round_robin();
      int k, last;
      logic [W-1:0] e;
      tick();
      f1[0] = 100; f2[0] = 500; f3[0] = 0;
      f1[1] = 200; f2[1] = 700; f3[1] = 0;
      f1[2] = 320; f2[2] = 0;   f3[2] = 600;
      f1[3] = 400; f2[3] = 0;   f3[3] = 0;
      for (int i = 0; i < 5; i++) push_exp(2'(i % N_CH));
      res_ready = 1'b1; req_valid = 4'hF; last = 0;
      for (int r = 0; r < 5; r++) begin
         wait_res(k);
         n_checks++; if (k == 0) begin n_fail++; $display("FAIL rr_timeout: result %0d not seen within 20 cycles", r); end
         pop_exp(e);
         n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL rr_result %0d: got ch %0d dec %b want ch %0d dec %b", r, res_ch, res_decision, e[4:3], e[2:0]); end
         if (r > 0) begin
            n_checks++; if (cyc - last != 3) begin n_fail++; $display("FAIL rr_spacing %0d: got %0d cycles want 3", r, cyc - last); end
         end
         last = cyc;
         if (r == 3) begin
            n_checks++; if (cls_cnt !== {4'd2, 4'd1, 4'd1}) begin n_fail++; $display("FAIL rr_counts4: got %h want 211", cls_cnt); end
         end
         if (r == 4) req_valid = '0;
      end
      n_checks++; if (cls_cnt !== {4'd2, 4'd1, 4'd2}) begin n_fail++; $display("FAIL rr_counts5: got %h want 212", cls_cnt); end
   endtask

   task automatic test_basic();
      int k;
      logic [W-1:0] e;
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      f1[0] = 300; f2[0] = 600; f3[0] = 700;
      req_valid = 4'b0001; res_ready = 1'b1;
      exp_q.push_back({2'd0, 3'b010});
      @(negedge CLK);
      n_checks++; if (cls_cnt !== '0) begin n_fail++; $display("FAIL basic_clear: got %h want 0", cls_cnt); end
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b want 0001", req_ready); end
      tick();
      req_valid = '0;
      wait_res(k);
      n_checks++; if (k != 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", k); end
      pop_exp(e);
      n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL basic_result: got ch %0d dec %b want ch %0d dec %b", res_ch, res_decision, e[4:3], e[2:0]); end
      n_checks++; if (cls_cnt !== {4'd0, 4'd1, 4'd0}) begin n_fail++; $display("FAIL basic_count: got %h want 010", cls_cnt); end
   endtask

   task automatic test_backpressure();
      int k;
      logic [W-1:0] e;
      tick();
      f1[1] = 100; f2[1] = 500; f3[1] = 0;
      f1[2] = 400; f2[2] = 0;   f3[2] = 0;
      push_exp(2'd1);
      push_exp(2'd2);
      res_ready = 1'b0; req_valid = 4'b0110;
      wait_res(k);
      n_checks++; if (k == 0) begin n_fail++; $display("FAIL bp_timeout: first result not seen"); end
      e = (exp_q.size() > 0) ? exp_q[0] : 'x;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge CLK);
         n_checks++; if (res_valid !== 1'b1 || res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL bp_hold %0d: got v %b ch %0d dec %b want 1/%0d/%b", i, res_valid, res_ch, res_decision, e[4:3], e[2:0]); end
         n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_no_accept %0d: got %b want 0000", i, req_ready); end
      end
      pop_exp(e);
      n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL bp_result1: got ch %0d dec %b want ch %0d dec %b", res_ch, res_decision, e[4:3], e[2:0]); end
      res_ready = 1'b1;
      @(negedge CLK);
      n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
      wait_res(k);
      n_checks++; if (k != 2) begin n_fail++; $display("FAIL bp_latency2: got %0d want 2", k); end
      pop_exp(e);
      n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL bp_result2: got ch %0d dec %b want ch %0d dec %b", res_ch, res_decision, e[4:3], e[2:0]); end
      req_valid = '0;
   endtask

   task automatic test_saturation();
      int k;
      logic [W-1:0] e;
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0; stub_en = 1'b1; stub_dec = 3'b001;
      for (int r = 0; r < 16; r++) exp_q.push_back({2'd0, 3'b001});
      req_valid = 4'b0001;
      for (int r = 0; r < 16; r++) begin
         wait_res(k);
         n_checks++; if (k == 0) begin n_fail++; $display("FAIL sat_timeout: result %0d not seen", r); end
         pop_exp(e);
         n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL sat_result %0d: got ch %0d dec %b want ch %0d dec %b", r, res_ch, res_decision, e[4:3], e[2:0]); end
         if (r == 14) begin
            n_checks++; if (cls_cnt !== {4'd0, 4'd0, 4'd15}) begin n_fail++; $display("FAIL sat_reach_max: got %h want 00f", cls_cnt); end
         end
         if (r == 15) req_valid = '0;
      end
      n_checks++; if (cls_cnt !== {4'd0, 4'd0, 4'd15}) begin n_fail++; $display("FAIL sat_hold: got %h want 00f", cls_cnt); end
      n_checks++; if (err_onehot !== 1'b0) begin n_fail++; $display("FAIL sat_err: got %b want 0", err_onehot); end
   endtask

   task automatic test_error();
      int k;
      logic [W-1:0] e;
      tick();
      stub_dec = 3'b011; req_valid = 4'b1000;
      exp_q.push_back({2'd3, 3'b011});
      wait_res(k);
      n_checks++; if (k == 0) begin n_fail++; $display("FAIL err_timeout: result not seen"); end
      pop_exp(e);
      n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL err_result: got ch %0d dec %b want ch %0d dec %b", res_ch, res_decision, e[4:3], e[2:0]); end
      n_checks++; if (err_onehot !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", err_onehot); end
      n_checks++; if (cls_cnt !== {4'd0, 4'd0, 4'd15}) begin n_fail++; $display("FAIL err_counts: got %h want 00f", cls_cnt); end
      req_valid = '0;
   endtask

   task automatic test_clear_priority();
      logic [W-1:0] e;
      tick();
      stub_dec = 3'b100; req_valid = 4'b0001;
      exp_q.push_back({2'd0, 3'b100});
      @(negedge CLK);
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL clr_grant: got %b want 0001", req_ready); end
      tick();
      req_valid = '0; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      @(negedge CLK);
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL clr_res_valid: got %b want 1", res_valid); end
      pop_exp(e);
      n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL clr_result: got ch %0d dec %b want ch %0d dec %b", res_ch, res_decision, e[4:3], e[2:0]); end
      n_checks++; if (cls_cnt !== '0 || err_onehot !== 1'b0) begin n_fail++; $display("FAIL clr_wins: got cnt %h err %b want 000/0", cls_cnt, err_onehot); end
   endtask

   task automatic test_reset_mid();
      int k;
      logic [W-1:0] e;
      tick();
      stub_en = 1'b0;
      f1[2] = 320; f2[2] = 0; f3[2] = 600;
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      n_checks++; if (tree_feat_1 !== 10'd320 || fsm_state !== 2'd1) begin n_fail++; $display("FAIL mid_eval: got feat %0d state %0d want 320/1", tree_feat_1, fsm_state); end
      #2;
      RST = 1'b0; req_valid = 4'hF;
      #1;
      n_checks++; if (res_valid !== 1'b0 || res_ch !== 2'd0 || res_decision !== 3'd0) begin n_fail++; $display("FAIL mid_outputs: got v %b ch %0d dec %b want 0", res_valid, res_ch, res_decision); end
      n_checks++; if (tree_feat_1 !== '0 || tree_feat_3 !== '0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_feat_ready: got %0d %0d %b want 0", tree_feat_1, tree_feat_3, req_ready); end
      tick();
      RST = 1'b1;
      f1[0] = 300; f2[0] = 600; f3[0] = 700;
      exp_q.push_back({2'd0, 3'b010});
      @(negedge CLK);
      n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
      wait_res(k);
      n_checks++; if (k != 2) begin n_fail++; $display("FAIL mid_latency: got %0d want 2", k); end
      pop_exp(e);
      n_checks++; if (res_ch !== e[4:3] || res_decision !== e[2:0]) begin n_fail++; $display("FAIL mid_result: got ch %0d dec %b want ch %0d dec %b", res_ch, res_decision, e[4:3], e[2:0]); end
      n_checks++; if (cls_cnt !== {4'd0, 4'd1, 4'd0} || err_onehot !== 1'b0) begin n_fail++; $display("FAIL mid_counts: got %h err %b want 010/0", cls_cnt, err_onehot); end
      req_valid = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_basic();
      test_backpressure();
      test_saturation();
      test_error();
      test_clear_priority();
      test_reset_mid();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
